// File: rtl/cipher_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : cipher_pkg
// Brief    : Shared types and helper functions for the nibble cipher
//            receive path (Gray decode, private-key expectation).
// Revision : 1.0  initial release
// ============================================================================
package cipher_pkg;

   typedef logic [3:0]  nibble_t;
   typedef logic [15:0] hex_t;

   // One-hot value presented on the output while no word has been decoded yet
   localparam hex_t HEX_RESET = 16'h0001;

   // Reflected-binary Gray code to plain binary, MSB first
   function automatic nibble_t gray2bin(input nibble_t g);
      nibble_t b;
      b[3] = g[3];
      b[2] = b[3] ^ g[2];
      b[1] = b[2] ^ g[1];
      b[0] = b[1] ^ g[0];
      return b;
   endfunction

   // Private key the encryptor would have attached: thermometer of popcount(g)
   function automatic nibble_t prv_expect(input nibble_t g);
      logic [2:0] pop;
      pop = {2'b00, g[0]} + {2'b00, g[1]} + {2'b00, g[2]} + {2'b00, g[3]};
      return {(pop == 3'd4), (pop >= 3'd3), (pop >= 3'd2), (pop >= 3'd1)};
   endfunction

endpackage
`default_nettype wire

// File: rtl/cipher_nibble_unmask.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : cipher_nibble_unmask
// Brief    : Combinational mask strip, Gray decode and inversion of one
//            encrypted nibble, plus the private-key integrity check.
//            Integrity check compiled in only with CIPHER_KEY_CHECK_EN.
// Revision : 1.0  initial release
// ============================================================================
module cipher_nibble_unmask
   import cipher_pkg::*;
(
   input  nibble_t enc,
   input  nibble_t prv,
   input  nibble_t pub,
   output nibble_t nib,
   output logic    err
);

   nibble_t w_g;

   // Remove both key masks, then undo the Gray coding and the inversion
   assign w_g = enc ^ pub ^ prv;
   assign nib = ~gray2bin(w_g);

`ifdef CIPHER_KEY_CHECK_EN
   // The private key must match the thermometer code of the unmasked word
   assign err = (prv_expect(w_g) != prv);
`else
   assign err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/cipher_stream_decryptor.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : cipher_stream_decryptor
// Brief    : Two-stage valid/ready decryptor: nibble unmask -> S1 register ->
//            one-hot decode -> S2 register, with saturating beat/error
//            counters. Integrity checking enabled by CIPHER_KEY_CHECK_EN.
// Revision : 1.0  initial release
// ============================================================================
module cipher_stream_decryptor
   import cipher_pkg::*;
#(
   parameter int CNT_W = 8
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             key_wr,
   input  logic [3:0]       pub_key_in,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_enc,
   input  logic [3:0]       in_prv,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [15:0]      out_hex,
   output logic             out_err,
   output logic [CNT_W-1:0] beat_cnt,
   output logic [CNT_W-1:0] err_cnt,
   input  logic             cnt_clr
);

   localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

   nibble_t          r_pub;
   logic             r_rdy_en;
   logic             r_s1_valid;
   nibble_t          r_s1_nib;
   logic             r_s1_err;
   logic             r_s2_valid;
   hex_t             r_s2_hex;
   logic             r_s2_err;
   logic [CNT_W-1:0] r_beat_cnt;

   nibble_t          w_nib;
   logic             w_err;
   logic             w_s2_free;
   logic             w_accept;
   logic             w_deliver;

   cipher_nibble_unmask u_unmask (
      .enc (in_enc),
      .prv (in_prv),
      .pub (r_pub),
      .nib (w_nib),
      .err (w_err)
   );

   // S2 can take a new word when it is empty or its word leaves this cycle
   assign w_s2_free = !r_s2_valid | out_ready;
   assign in_ready  = r_rdy_en & (!r_s1_valid | w_s2_free);
   assign w_accept  = in_valid & in_ready;
   assign w_deliver = r_s2_valid & out_ready;

   assign out_valid = r_s2_valid;
   assign out_hex   = r_s2_hex;
   assign out_err   = r_s2_err;
   assign beat_cnt  = r_beat_cnt;

   // Input side stays closed while reset is held, opens on the first edge after
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_rdy_en <= 1'b0;
      else        r_rdy_en <= 1'b1;
   end

   // Public key register; a beat accepted on the write edge still sees the old key
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      r_pub <= 4'h0;
      else if (key_wr) r_pub <= pub_key_in;
   end

   // Stage S1: capture decoded nibble and check result on accept
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_nib   <= 4'h0;
         r_s1_err   <= 1'b0;
      end else if (w_accept) begin
         r_s1_valid <= 1'b1;
         r_s1_nib   <= w_nib;
         r_s1_err   <= w_err;
      end else if (w_s2_free) begin
         r_s1_valid <= 1'b0;
      end
   end

   // Stage S2: one-hot word, held stable while downstream stalls
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s2_valid <= 1'b0;
         r_s2_hex   <= HEX_RESET;
         r_s2_err   <= 1'b0;
      end else if (w_s2_free) begin
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_s2_hex <= HEX_RESET << r_s1_nib;
            r_s2_err <= r_s1_err;
         end
      end
   end

   // Delivered-word counter, saturating; clear wins over increment
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                     r_beat_cnt <= '0;
      else if (cnt_clr)                               r_beat_cnt <= '0;
      else if (w_deliver && (r_beat_cnt != '1))       r_beat_cnt <= r_beat_cnt + c_cnt_one;
   end

`ifdef CIPHER_KEY_CHECK_EN
   logic [CNT_W-1:0] r_err_cnt;

   // Delivered-with-error counter, saturating; clear wins over increment
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                               r_err_cnt <= '0;
      else if (cnt_clr)                                         r_err_cnt <= '0;
      else if (w_deliver && r_s2_err && (r_err_cnt != '1))      r_err_cnt <= r_err_cnt + c_cnt_one;
   end

   assign err_cnt = r_err_cnt;
`else
   assign err_cnt = '0;
`endif

endmodule
`default_nettype wire
